// File: rtl/mult_arb_pkg.sv
// Shared widths and the response-queue entry type for the multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned P_W    = 16;
  localparam int unsigned STAT_W = 16;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned ID_W   = 3;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
  } rsp_entry_t;

endpackage

// File: rtl/mult_arb_fifo.sv
// Synchronous response FIFO of rsp_entry_t; pointers wrap modulo DEPTH (any depth, not just 2^n).
module mult_arb_fifo
  import mult_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rsp_entry_t    din,
  input  logic          pop,
  output rsp_entry_t    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == int'(DEPTH) - 1) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && !empty;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The credit scheme must never let a capture land on a full queue.
  always @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end

endmodule

// File: rtl/pp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier datapath among NREQ requesters.
// Optional per-requester grant counters are enabled by defining PP_MULT_ARB_STATS_EN.
module pp_mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = PIPE_LAT + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [OP_W*NREQ-1:0]      req_a,
  input  logic [OP_W*NREQ-1:0]      req_b,
  output logic [OP_W-1:0]           mul_a,
  output logic [OP_W-1:0]           mul_b,
  input  logic [P_W-1:0]            mul_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [P_W-1:0]            rsp_p
`ifdef PP_MULT_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NREQ*STAT_W-1:0]    stat_grants
`endif
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx, cand;
  logic             grant_any;
  logic [CW-1:0]    inflight, fifo_count;
  logic             issue_ok;
  logic             cap_valid;
  logic [IDX_W-1:0] cap_tag;
  logic             fifo_full, fifo_empty;
  rsp_entry_t       push_entry, head_entry;

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  assign issue_ok = (int'(inflight) + int'(fifo_count)) < int'(FIFO_DEPTH);

  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (issue_ok && !rst) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        cand = IDX_W'((int'(rr_ptr) + k) % int'(NREQ));
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  assign mul_a = grant_any ? req_a[grant_idx*OP_W +: OP_W] : '0;
  assign mul_b = grant_any ? req_b[grant_idx*OP_W +: OP_W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= IDX_W'(NREQ - 1);
      inflight <= '0;
    end else begin
      if (grant_any) rr_ptr <= grant_idx;
      case ({grant_any, cap_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  if (PIPE_LAT == 0) begin : g_comb
    assign cap_valid = grant_any;
    assign cap_tag   = grant_idx;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] vld_q;
    logic [IDX_W-1:0]    tag_q [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int s = 0; s < int'(PIPE_LAT); s++) tag_q[s] <= '0;
      end else begin
        vld_q[0] <= grant_any;
        tag_q[0] <= grant_idx;
        for (int s = 1; s < int'(PIPE_LAT); s++) begin
          vld_q[s] <= vld_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      end
    end

    assign cap_valid = vld_q[PIPE_LAT-1];
    assign cap_tag   = tag_q[PIPE_LAT-1];
  end

  assign push_entry = '{id: ID_W'(cap_tag), p: mul_p};

  mult_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_valid),
    .din   (push_entry),
    .pop   (rsp_ready),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = head_entry.id[IDX_W-1:0];
  assign rsp_p     = head_entry.p;

`ifdef PP_MULT_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREQ); i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < int'(NREQ); i++) stat_q[i] <= '0;
    end else if (grant_any && (stat_q[grant_idx] != '1)) begin
      stat_q[grant_idx] <= stat_q[grant_idx] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: doc/pp_mult_arbiter.md
Name: pp_mult_arbiter

Overview:
- Shares one 8x8 approximate multiplier datapath among NREQ requesters. The datapath is the partial-product generator followed by the dual-stage 4:2 compressor tree.
- Round-robin grant; issues at most one operand pair per cycle into the non-stallable datapath pipeline.
- Tags each issue with the requester ID and captures the 16-bit product after PIPE_LAT cycles.
- Results go to a response FIFO with valid/ready handshake. A credit scheme ensures the datapath never needs to stall.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PIPE_LAT, 2, datapath latency in cycles from mul_a/mul_b to mul_p (0..4; 0 = combinational).
- FIFO_DEPTH, PIPE_LAT+2, response FIFO entries; also the total credit count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  8*NREQ  multiplicand, requester i at [8i+7:8i].
- req_b  in  8*NREQ  multiplier, requester i at [8i+7:8i].
- mul_a  out  8  operand A to shared datapath.
- mul_b  out  8  operand B to shared datapath.
- mul_p  in  16  product from shared datapath.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  $clog2(NREQ)  requester that owns rsp_p.
- rsp_p  out  16  product.

Behaviour:
- Reset (asynchronous, active-high; clears everything immediately):
  - rr_ptr = NREQ-1, so requester 0 has first priority.
  - Pipeline valid/tag stages cleared, FIFO empty, inflight = 0.
  - Outputs: req_ready = 0, mul_a = mul_b = 0, rsp_valid = 0, rsp_id = 0, rsp_p = 0.
- Reset asserted mid-operation drops all in-flight and queued results. No response is produced for them.
- Credit rule: issue_ok = (inflight + fifo_count) < FIFO_DEPTH, computed from registered values only. A pop in cycle t frees its credit at t+1.
- Grant:
  - When issue_ok, grant the first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready = one-hot grant. It is combinational from req_valid and state, and is 0 when !issue_ok.
  - A transfer occurs when req_valid[i] && req_ready[i]. rr_ptr <= i on transfer. rr_ptr is unchanged with no transfer.
- Issue:
  - On transfer, mul_a/mul_b = the granted requester's operands, combinationally in the same cycle; otherwise they are 0.
  - A shift register of PIPE_LAT stages (valid + tag) tracks the issue.
  - inflight increments on issue and decrements on capture. Simultaneous issue and capture leaves it unchanged.
- Capture:
  - When the tag pipe's last stage is valid (PIPE_LAT=0: the issue cycle itself), push {tag, mul_p} into the FIFO that cycle.
  - Total latency from transfer to rsp_valid = PIPE_LAT+1 cycles with an empty FIFO.
- FIFO:
  - rsp_valid = !empty; rsp_id/rsp_p = head entry, registered.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Push to a full FIFO is impossible by the credit rule. This is an assertion target.
- Ordering: responses are returned in issue order, which is global, not per-requester.
- Read and write pointers wrap modulo FIFO_DEPTH. Count is held in $clog2(FIFO_DEPTH+1) bits.
- Backpressure: with rsp_ready held low, the issue count caps at FIFO_DEPTH; req_ready stays 0 thereafter.

Optional Feature:
- Macro: PP_MULT_ARB_STATS_EN.
- Defined:
  - Adds output port stat_grants, NREQ*16 bits: per-requester saturating grant counters, incremented on each transfer.
  - Adds input port stat_clr: synchronous clear, which takes priority over increment.
  - Counters are cleared by rst.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package mult_arb_pkg holds:
  - OP_W = 8 and P_W = 16.
  - STAT_W = 16.
  - The rsp_entry_t struct {id, p} used by the FIFO.
- Sub-module mult_arb_fifo: a parameterised synchronous FIFO holding rsp_entry_t, providing count, full and empty.
- The arbiter, credit logic and tag pipe stay in pp_mult_arbiter.

Test Plan:
- Single request, PIPE_LAT=2, req0 a=0x0F b=0x03, rsp_ready=1:
  - req_ready[0] is 1 in the same cycle.
  - rsp_valid rises 3 cycles later with rsp_id=0 and rsp_p equal to the reference model of mul_p (exact 0x002D for the exact-model stub).
- All 4 requesters valid continuously, rsp_ready=1:
  - Grants follow 0,1,2,3,0,... with one per cycle and no gaps.
  - rsp_id follows the same sequence.
- rsp_ready=0 with all requesters valid:
  - Exactly FIFO_DEPTH=4 transfers, then req_ready stays 0.
  - Raising rsp_ready for 1 cycle pops 1 entry and allows exactly 1 new transfer the following cycle.
- Only req2 valid with rr_ptr=2: req2 is granted every cycle (wrap search returns to itself).
- rst asserted 1 cycle after 2 issues:
  - All outputs go to 0 immediately.
  - After release, no stale response appears and the first grant goes to req0.
- With PP_MULT_ARB_STATS_EN, 300 grants to req1 with rsp_ready=1:
  - stat_grants[31:16] = 300.
  - stat_clr returns it to 0 on the next cycle.
  - A separate 70000-grant run saturates the counter at 0xFFFF.
